// File: rtl/alu_seq.sv
// alu_seq: handshaked Hack-style ALU with multiply, shift-left-logical and shift-right-arithmetic modes.
// Latency: 1 cycle from the accepting edge for Hack/shift modes; WIDTH+1 cycles for multiply (one shift-add per cycle).
// Backpressure: in_ready is high only in IDLE; a result is held in DONE until out_ready, and in_valid is ignored meanwhile.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   request handshake; x, y, ctrl, mode sampled at the accepting edge
//   x, y                WIDTH-bit operands
//   ctrl                Hack bits [5]=zx [4]=nx [3]=zy [2]=ny [1]=f [0]=no
//   mode                00=Hack, 01=multiply, 10=shift left logical, 11=shift right arithmetic
//   out_valid/out_ready result handshake
//   out, zr, ng, cy, ov registered result and flags, held until the next result
module alu_seq #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [1:0]     MODE_HACK = 2'b00;
  localparam logic [1:0]     MODE_MUL  = 2'b01;
  localparam logic [1:0]     MODE_SLL  = 2'b10;
  localparam logic [1:0]     MODE_SRA  = 2'b11;
  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d, ng_q, ng_d, cy_q, cy_d, ov_q, ov_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             no_q, no_d;

  // Operand pre-processing shared by every mode.
  logic [WIDTH-1:0] xz, xp, yz, yp;
  assign xz = ctrl[5] ? '0 : x;
  assign xp = ctrl[4] ? ~xz : xz;
  assign yz = ctrl[3] ? '0 : y;
  assign yp = ctrl[2] ? ~yz : yz;

  // Extra bit on the adder gives the carry out directly.
  logic [WIDTH:0]   sum;
  logic             add_ov;
  logic [SHW-1:0]   shamt;
  assign sum    = {1'b0, xp} + {1'b0, yp};
  // Signed overflow: operands agree in sign but the sum does not.
  assign add_ov = (xp[WIDTH-1] == yp[WIDTH-1]) && (sum[WIDTH-1] != xp[WIDTH-1]);
  assign shamt  = yp[SHW-1:0];

  // Single-cycle core result; multiply is produced by the iterative path instead.
  logic [WIDTH-1:0] core_r, quick_res;
  logic             arith_flags;
  always_comb begin
    core_r = '0;
    unique case (mode)
      MODE_HACK: core_r = ctrl[1] ? sum[WIDTH-1:0] : (xp & yp);
      MODE_SLL:  core_r = xp << shamt;
      MODE_SRA:  core_r = $signed(xp) >>> shamt;
      default:   core_r = '0;
    endcase
  end
  assign quick_res   = ctrl[0] ? ~core_r : core_r;
  assign arith_flags = (mode == MODE_HACK) && ctrl[1];

  // One shift-add step: accumulate the multiplicand when the current multiplier bit is set.
  logic [WIDTH-1:0] acc_step, mul_res;
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_res  = no_q ? ~acc_step : acc_step;

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    zr_d     = zr_q;
    ng_d     = ng_q;
    cy_d     = cy_q;
    ov_d     = ov_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    no_d     = no_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (mode == MODE_MUL) begin
            state_d  = BUSY;
            mcand_d  = xp;
            mplier_d = yp;
            acc_d    = '0;
            cnt_d    = '0;
            no_d     = ctrl[0];
          end else begin
            state_d = DONE;
            out_d   = quick_res;
            zr_d    = (quick_res == '0);
            ng_d    = quick_res[WIDTH-1];
            cy_d    = arith_flags & sum[WIDTH];
            ov_d    = arith_flags & add_ov;
          end
        end
      end
      BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
          out_d   = mul_res;
          zr_d    = (mul_res == '0);
          ng_d    = mul_res[WIDTH-1];
          cy_d    = 1'b0;
          ov_d    = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      out_q    <= '0;
      zr_q     <= 1'b0;
      ng_q     <= 1'b0;
      cy_q     <= 1'b0;
      ov_q     <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      no_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      zr_q     <= zr_d;
      ng_q     <= ng_d;
      cy_q     <= cy_d;
      ov_q     <= ov_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      no_q     <= no_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign cy        = cy_q;
  assign ov        = ov_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's combinational Hack-style ALU.
- Keeps the six Hack control bits (zx, nx, zy, ny, f, no) and adds three modes: multi-cycle shift-add multiply, logical shift left, arithmetic shift right.
- Adds registered outputs with carry and overflow flags.
- Sits between the CPU decode stage and the register write-back path, using valid/ready on both sides.

Parameters:
- WIDTH, 16, operand and result width; power of two, at least 4.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from y; derived, not overridden.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation request valid
- in_ready  out  1  block can accept an operation
- x  in  WIDTH  operand x
- y  in  WIDTH  operand y
- ctrl  in  6  Hack control bits: [5]=zx [4]=nx [3]=zy [2]=ny [1]=f [0]=no
- mode  in  2  00=Hack, 01=multiply, 10=shift left logical, 11=shift right arithmetic
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out  out  WIDTH  result
- zr  out  1  out == 0
- ng  out  1  out[WIDTH-1]
- cy  out  1  carry out of the adder
- ov  out  1  signed overflow of the adder

Behaviour:
- Reset: state=IDLE; out=0; zr=0, ng=0, cy=0, ov=0; out_valid=0.
  - Reset wins over every other event.
  - Any in-flight operation is discarded and produces no out_valid.
- States: IDLE, BUSY, DONE. in_ready=1 only in IDLE, 0 in BUSY and DONE. in_ready is combinational from state.
- Accept: in_valid && in_ready at a rising edge.
  - x, y, ctrl and mode are sampled only at the accepting edge.
  - Later input changes are ignored until the next accept.
- Pre-processing, applied in every mode:
  - x' = zx ? 0 : x, then nx inverts x'.
  - y' is formed the same way from y with zy and ny.
- Core result R by mode:
  - 00: f ? x'+y' (mod 2^WIDTH) : x'&y'.
  - 01: low WIDTH bits of the unsigned product x'*y'.
  - 10: x' << y'[SHW-1:0].
  - 11: x' >>> y'[SHW-1:0] (sign-filled).
  - Shift amounts never reach WIDTH because only SHW bits are used.
- Output: out = no ? ~R : R, applied in every mode.
- Flags are registered together with out:
  - zr = (out==0).
  - ng = out[WIDTH-1].
  - cy = carry out of x'+y'; ov = signed overflow of x'+y'. Both are valid only for mode 00 with f=1, and are 0 otherwise.
  - Flags are taken after no; cy and ov are not inverted by no.
- Timing, modes 00/10/11:
  - Result is computed at the accepting edge and the state moves IDLE->DONE.
  - out_valid=1 in the cycle after accept (latency 1).
- Timing, mode 01:
  - At the accepting edge: state IDLE->BUSY; load multiplicand=x', multiplier=y', accumulator=0, counter=0.
  - Each BUSY edge runs one shift-add iteration on multiplier bit 0.
  - After the WIDTH-th iteration, the state moves BUSY->DONE with the result registered.
  - out_valid=1 first in the cycle after accept edge + WIDTH (latency WIDTH+1 cycles).
- DONE:
  - out_valid=1; out and all flags are held stable.
  - out_valid && out_ready at an edge -> IDLE, out_valid=0 next cycle.
  - out and flags keep their last value after the handshake until the next result.
  - No accept is possible in DONE. Best throughput is one op per 2 cycles (non-multiply).
- Backpressure: out_ready may stay low indefinitely, and in_valid pulses during BUSY/DONE are dropped. The requester must hold in_valid until in_ready.

Test Plan (WIDTH=16):
1. Add/AND: mode=00, ctrl=000010, x=5, y=7, accept, out_ready=1.
   - Required: out_valid exactly 1 cycle later, out=12, zr=0, ng=0, cy=0, ov=0, then back to IDLE.
   - Repeat with ctrl=000000, x=0x00F0, y=0x0FF0: out=0x00F0.
2. Flags: mode=00, ctrl=001110 (x-1), x=0 -> out=0xFFFF, ng=1, cy=0, ov=0.
   - ctrl=000010, x=0x7FFF, y=1 -> out=0x8000, ov=1, ng=1, cy=0.
   - x=0xFFFF, y=1 -> out=0, zr=1, cy=1.
3. Multiply: mode=01, ctrl=000000, x=300, y=300 -> out=0x5F90 (24464).
   - out_valid first high 17 cycles after the accepting edge's cycle.
   - in_ready=0 throughout BUSY.
   - x=0, y=0x1234 -> out=0, zr=1.
4. Backpressure: after a single-cycle op, hold out_ready=0 for 5 cycles while toggling x, y and in_valid.
   - Required: out_valid stays 1; out and flags are unchanged; no second op is accepted; IDLE follows the first out_ready=1 edge.
5. Reset mid-operation: start mode=01, assert reset for 1 cycle at the 8th BUSY cycle.
   - Required: out_valid never rises for that op; out=0, flags=0, in_ready=1 next cycle.
   - Then mode=01, x=3, y=4 -> out=12.
6. Shifts:
   - mode=11, ctrl=000000, x=0x8000, y=3 -> out=0xF000, ng=1.
   - mode=10, x=1, y=0x0013 (amount=3) -> out=0x0008.
   - mode=10, ctrl=000001, x=1, y=0 -> out=0xFFFE.
